// File: rtl/usb_in_endpoint_scheduler.sv
// usb_in_endpoint_scheduler: IN token sequencer with per-endpoint replay buffers and DATA0/DATA1 toggles
module usb_in_endpoint_scheduler #(
  parameter int NUM_EP  = 2,
  parameter int MAX_PKT = 8,
  parameter int AW      = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   token_valid_i,
  input  logic [3:0]             token_endp_i,
  input  logic [NUM_EP-1:0]      stall_i,
  input  logic [NUM_EP-1:0]      toggle_clr_i,
  input  logic [8*NUM_EP-1:0]    fifo_q_i,
  input  logic [NUM_EP-1:0]      fifo_empty_i,
  input  logic [AW*NUM_EP-1:0]   fifo_usedw_i,
  output logic [NUM_EP-1:0]      fifo_rdreq_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_last_o,
  input  logic                   tx_ready_i,
  input  logic                   hs_ack_i,
  input  logic                   hs_timeout_i,
  output logic                   busy_o
);
  localparam int EW = NUM_EP > 1 ? $clog2(NUM_EP) : 1;
  localparam int LW = $clog2(MAX_PKT + 1);
  localparam int PW = MAX_PKT > 1 ? $clog2(MAX_PKT) : 1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, HS} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     ep_q, ep_d;
  logic [LW-1:0]     n_q, n_d, cnt_q, cnt_d, idx_q, idx_d;
  logic [7:0]        hs_pid_q, hs_pid_d;
  logic              rdv_q;
  logic [NUM_EP-1:0] toggle_q, held_q, pend_q;
  logic [LW-1:0]     len_q [NUM_EP];
  logic [7:0]        buf_q [NUM_EP][MAX_PKT];
  logic [EW-1:0]     tok_ep;
  logic [AW-1:0]     tok_used;
  logic              tok_ok;

  assign busy_o = state_q != IDLE;

  always_comb begin
    tok_ep = EW'(token_endp_i);
    tok_ok = token_valid_i && (32'(token_endp_i) < NUM_EP);
    tok_used = fifo_usedw_i[tok_ep*AW +: AW];
    state_d = state_q;
    ep_d = ep_q;
    n_d = n_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    hs_pid_d = hs_pid_q;
    fifo_rdreq_o = '0;
    tx_valid_o = 1'b0;
    tx_data_o = '0;
    tx_last_o = 1'b0;
    case (state_q)
      IDLE: if (tok_ok) begin
        ep_d = tok_ep;
        cnt_d = '0;
        idx_d = '0;
        n_d = (tok_used > AW'(MAX_PKT)) ? LW'(MAX_PKT) : LW'(tok_used);
        hs_pid_d = stall_i[tok_ep] ? PID_STALL : PID_NAK;
        // a toggle_clr arriving with the token already discards the held packet
        state_d = stall_i[tok_ep] ? HS :
                  (held_q[tok_ep] && !toggle_clr_i[tok_ep]) ? SEND :
                  fifo_empty_i[tok_ep] ? HS : LOAD;
      end
      LOAD: begin
        fifo_rdreq_o[ep_q] = cnt_q != n_q;
        cnt_d = cnt_q + LW'(cnt_q != n_q);
        state_d = (cnt_q == n_q) ? SEND : LOAD;
      end
      SEND: begin
        tx_valid_o = 1'b1;
        tx_last_o = idx_q == len_q[ep_q];
        tx_data_o = (idx_q == '0) ? (toggle_q[ep_q] ? PID_DATA1 : PID_DATA0) :
                    buf_q[ep_q][PW'(idx_q - LW'(1))];
        idx_d = tx_ready_i ? idx_q + LW'(1) : idx_q;
        state_d = (tx_ready_i && tx_last_o) ? WAIT : SEND;
      end
      WAIT: state_d = (hs_ack_i || hs_timeout_i) ? IDLE : WAIT;
      HS: begin
        tx_valid_o = 1'b1;
        tx_data_o = hs_pid_q;
        tx_last_o = 1'b1;
        state_d = tx_ready_i ? IDLE : HS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ep_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      hs_pid_q <= '0;
      rdv_q <= 1'b0;
      toggle_q <= '0;
      held_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < NUM_EP; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ep_q <= ep_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hs_pid_q <= hs_pid_d;
      rdv_q <= |fifo_rdreq_o;
      // fifo_q lags rdreq by one cycle, so the capture slot is cnt_q-1
      if (rdv_q) buf_q[ep_q][PW'(cnt_q - LW'(1))] <= fifo_q_i[ep_q*8 +: 8];
      if (state_q == LOAD && cnt_q == n_q) begin
        len_q[ep_q] <= n_q;
        held_q[ep_q] <= 1'b1;
      end
      if (state_q == WAIT && hs_ack_i) begin
        toggle_q[ep_q] <= ~toggle_q[ep_q];
        held_q[ep_q] <= 1'b0;
      end
      // clears for the active endpoint wait until it returns to IDLE
      for (int i = 0; i < NUM_EP; i++)
        if (state_q == IDLE || state_d == IDLE || ep_q != EW'(i)) begin
          if (toggle_clr_i[i] || pend_q[i]) begin
            toggle_q[i] <= 1'b0;
            held_q[i] <= 1'b0;
          end
          pend_q[i] <= 1'b0;
        end else if (toggle_clr_i[i]) pend_q[i] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_usb_in_endpoint_scheduler.sv
// tb_usb_in_endpoint_scheduler: directed checks of PID/toggle, replay, NAK/STALL, back-pressure and reset
module tb_usb_in_endpoint_scheduler;
  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        token_valid_i = 1'b0;
  logic [3:0]  token_endp_i = '0;
  logic [1:0]  stall_i = '0;
  logic [1:0]  toggle_clr_i = '0;
  logic [15:0] fifo_q_i = '0;
  logic [1:0]  fifo_empty_i = 2'b11;
  logic [7:0]  fifo_usedw_i = '0;
  logic [1:0]  fifo_rdreq_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_last_o;
  logic        tx_ready_i = 1'b1;
  logic        hs_ack_i = 1'b0;
  logic        hs_timeout_i = 1'b0;
  logic        busy_o;

  logic [7:0] fq0[$], fq1[$], rx[$], ex[$];
  logic [1:0] rdq = '0;
  int rd[2];
  int last_at = -1;
  bit seen_last = 0;
  int total = 0, bad = 0;

  usb_in_endpoint_scheduler dut (
    .clk_i(clk), .reset_i(reset_i), .token_valid_i(token_valid_i), .token_endp_i(token_endp_i),
    .stall_i(stall_i), .toggle_clr_i(toggle_clr_i), .fifo_q_i(fifo_q_i), .fifo_empty_i(fifo_empty_i),
    .fifo_usedw_i(fifo_usedw_i), .fifo_rdreq_o(fifo_rdreq_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i), .hs_ack_i(hs_ack_i),
    .hs_timeout_i(hs_timeout_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // FIFO model: q appears one cycle after rdreq
  always @(posedge clk) begin
    if (rdq[0]) fifo_q_i[7:0] <= fq0.pop_front();
    if (rdq[1]) fifo_q_i[15:8] <= fq1.pop_front();
  end

  always @(negedge clk) begin
    fifo_usedw_i = {4'(fq1.size()), 4'(fq0.size())};
    fifo_empty_i = {fq1.size() == 0, fq0.size() == 0};
    rdq = fifo_rdreq_o;
    if (reset_i) begin
      for (int e = 0; e < 2; e++) rd[e] += int'(fifo_rdreq_o[e]);
      if (tx_valid_o && tx_ready_i) begin
        if (tx_last_o && !seen_last) last_at = rx.size();
        rx.push_back(tx_data_o);
        if (tx_last_o) seen_last = 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tok(input logic [3:0] e);
    rx.delete();
    rd[0] = 0;
    rd[1] = 0;
    last_at = -1;
    seen_last = 0;
    token_endp_i = e;
    token_valid_i = 1'b1;
    step();
    token_valid_i = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n);
    for (int k = 0; k < 200 && rx.size() < n && !seen_last; k++) step();
    chk({tag, "_tmo"}, 32'(rx.size() >= n || seen_last), 1);
  endtask

  task automatic in_tok(input string tag, input logic [3:0] e);
    tok(e);
    wait_rx(tag, 99);
  endtask

  task automatic expect_pkt(input string tag, input int e, input int nrd);
    chk({tag, "_len"}, rx.size(), ex.size());
    foreach (ex[i]) if (i < rx.size()) chk(tag, rx[i], ex[i]);
    chk({tag, "_last"}, last_at, ex.size() - 1);
    chk({tag, "_rd"}, rd[e], nrd);
  endtask

  task automatic hs(input bit ack);
    hs_ack_i = ack;
    hs_timeout_i = !ack;
    step();
    hs_ack_i = 1'b0;
    hs_timeout_i = 1'b0;
    chk("hs_idle", busy_o, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", tx_valid_o, 0);
    chk("rst_rdreq", fifo_rdreq_o, 0);
    chk("rst_data", tx_data_o, 0);
    chk("rst_last", tx_last_o, 0);
    reset_i = 1'b1;

    fq1 = '{8'h11, 8'h22, 8'h33};
    in_tok("t1a", 1);
    ex = '{8'hC3, 8'h11, 8'h22, 8'h33};
    expect_pkt("t1a", 1, 3);
    chk("t1_wait_busy", busy_o, 1);
    hs(1);
    fq1 = '{8'h44, 8'h55, 8'h66};
    in_tok("t1b", 1);
    ex = '{8'h4B, 8'h44, 8'h55, 8'h66};
    expect_pkt("t1b", 1, 3);
    hs(1);

    for (int i = 1; i <= 12; i++) fq0.push_back(8'(i));
    in_tok("t2a", 0);
    ex = '{8'hC3};
    for (int i = 1; i <= 8; i++) ex.push_back(8'(i));
    expect_pkt("t2a", 0, 8);
    hs(1);
    in_tok("t2b", 0);
    ex = '{8'h4B, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    expect_pkt("t2b", 0, 4);
    hs(1);
    chk("t2_fifo_empty", fq0.size(), 0);

    fq1 = '{8'hA1, 8'hA2};
    in_tok("t3a", 1);
    ex = '{8'hC3, 8'hA1, 8'hA2};
    expect_pkt("t3a", 1, 2);
    hs(0);
    in_tok("t3b", 1);
    expect_pkt("t3b", 1, 0);
    hs(1);
    fq1 = '{8'hB1};
    in_tok("t3c", 1);
    ex = '{8'h4B, 8'hB1};
    expect_pkt("t3c", 1, 1);
    hs(1);

    in_tok("t4nak", 0);
    ex = '{8'h5A};
    expect_pkt("t4nak", 0, 0);
    chk("t4nak_idle", busy_o, 0);
    fq0 = '{8'hC1};
    in_tok("t4a", 0);
    ex = '{8'hC3, 8'hC1};
    expect_pkt("t4a", 0, 1);
    hs(1);
    stall_i = 2'b01;
    in_tok("t4stall", 0);
    ex = '{8'h1E};
    expect_pkt("t4stall", 0, 0);
    stall_i = 2'b00;
    fq0 = '{8'hD1};
    in_tok("t4b", 0);
    ex = '{8'h4B, 8'hD1};
    expect_pkt("t4b", 0, 1);
    hs(0);
    stall_i = 2'b01;
    in_tok("t4hstall", 0);
    ex = '{8'h1E};
    expect_pkt("t4hstall", 0, 0);
    stall_i = 2'b00;
    in_tok("t4c", 0);
    ex = '{8'h4B, 8'hD1};
    expect_pkt("t4c", 0, 0);
    hs(1);

    fq1 = '{8'hE1, 8'hE2, 8'hE3};
    tok(1);
    wait_rx("t5", 2);
    tx_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_hold_data", tx_data_o, 8'hE2);
      chk("t5_hold_valid", tx_valid_o, 1);
    end
    tx_ready_i = 1'b1;
    wait_rx("t5", 99);
    ex = '{8'hC3, 8'hE1, 8'hE2, 8'hE3};
    expect_pkt("t5", 1, 3);
    hs(1);

    fq1 = '{8'hF1, 8'hF2, 8'hF3};
    tok(1);
    wait_rx("t5r", 2);
    reset_i = 1'b0;
    step();
    chk("t5r_valid", tx_valid_o, 0);
    chk("t5r_busy", busy_o, 0);
    reset_i = 1'b1;
    rd[1] = 0;
    step();
    step();
    chk("t5r_no_rd", rd[1], 0);
    fq1 = '{8'hF4};
    in_tok("t5r_next", 1);
    ex = '{8'hC3, 8'hF4};
    expect_pkt("t5r_next", 1, 1);
    hs(1);

    fq1 = '{8'h61, 8'h62};
    in_tok("t6a", 1);
    ex = '{8'h4B, 8'h61, 8'h62};
    expect_pkt("t6a", 1, 2);
    hs(0);
    fq1 = '{8'h71};
    toggle_clr_i = 2'b10;
    step();
    toggle_clr_i = 2'b00;
    in_tok("t6b", 1);
    ex = '{8'hC3, 8'h71};
    expect_pkt("t6b", 1, 1);
    hs(1);
    fq1 = '{8'h81};
    in_tok("t6c", 1);
    ex = '{8'h4B, 8'h81};
    expect_pkt("t6c", 1, 1);
    toggle_clr_i = 2'b10;
    step();
    toggle_clr_i = 2'b00;
    hs(0);
    fq1 = '{8'h91};
    in_tok("t6d", 1);
    ex = '{8'hC3, 8'h91};
    expect_pkt("t6d", 1, 1);
    hs(1);

    rd[0] = 0;
    rd[1] = 0;
    token_endp_i = 4'd5;
    token_valid_i = 1'b1;
    step();
    token_valid_i = 1'b0;
    chk("t7_busy", busy_o, 0);
    step();
    chk("t7_valid", tx_valid_o, 0);
    chk("t7_rd", rd[0] + rd[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_in_endpoint_scheduler.md
Name: usb_in_endpoint_scheduler

Overview:
- Sequences IN transactions for the device's IN endpoint FIFOs (EP0 IN, EP1 IN) on behalf of the SIE transmit path.
- On each decoded IN token it does one of three things:
  - loads a packet from the addressed FIFO into a per-endpoint replay buffer and streams PID plus payload to the transmitter;
  - answers NAK;
  - answers STALL.
- Tracks per-endpoint DATA0/DATA1 toggle and retransmits the held packet after a missing handshake.
- Sits between the token decoder and the transceiver TX interface, and owns rdreq of the IN FIFOs.

Parameters:
- NUM_EP, 2, number of IN endpoints served (index 0..NUM_EP-1).
- MAX_PKT, 8, maximum payload bytes per packet (low-speed limit).
- AW, 4, width of FIFO usedw.

Ports:
- clk  in  1  system clock (24 MHz).
- reset  in  1  synchronous, active-low reset (0 = reset).
- token_valid  in  1  one-cycle strobe: IN token addressed to this device.
- token_endp  in  4  endpoint number of the token.
- stall  in  NUM_EP  per-endpoint halt flag.
- toggle_clr  in  NUM_EP  one-cycle per-endpoint strobe: force toggle to DATA0 and discard the held packet (SET_CONFIGURATION, CLEAR_FEATURE).
- fifo_q  in  8*NUM_EP  FIFO read data; q is valid one cycle after rdreq.
- fifo_empty  in  NUM_EP  FIFO empty flags.
- fifo_usedw  in  AW*NUM_EP  FIFO fill levels.
- fifo_rdreq  out  NUM_EP  FIFO read strobes.
- tx_valid  out  1  byte valid to transmitter.
- tx_data  out  8  byte (PID byte first).
- tx_last  out  1  marks the final byte of the packet.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- hs_ack  in  1  one-cycle strobe: host ACK received.
- hs_timeout  in  1  one-cycle strobe: handshake timeout expired.
- busy  out  1  scheduler not in IDLE.

Behaviour:
- Reset (reset==0 on a clk edge) clears everything:
  - fifo_rdreq=0, tx_valid=0, tx_data=0, tx_last=0, busy=0;
  - all toggles = DATA0, all held flags = 0;
  - state = IDLE.
- Reset mid-packet aborts immediately. No further rdreq is issued.
- States and transitions:
  - IDLE: on token_valid, latch ep=token_endp.
    - token_endp >= NUM_EP: the token is ignored and the state stays IDLE.
    - stall[ep]=1 -> HS with PID STALL (0x1E). The held packet is kept.
    - held[ep]=1 -> SEND. This is a retransmit; the FIFO is not read.
    - fifo_empty[ep]=1 -> HS with PID NAK (0x5A).
    - Otherwise -> LOAD, with n = min(usedw[ep], MAX_PKT).
  - LOAD:
    - Assert fifo_rdreq[ep] for exactly n consecutive cycles.
    - Capture fifo_q into buf[ep][i] one cycle after each rdreq.
    - Store len[ep]=n and set held[ep]=1.
    - Go to SEND the cycle after the last capture. Load latency is n+1 cycles.
  - SEND:
    - Drive the PID byte: DATA0 0xC3 if toggle[ep]=0, else DATA1 0x4B.
    - Then drive buf[ep][0..len-1].
    - Hold tx_valid and tx_data stable until tx_ready. Advance one byte per tx_ready cycle.
    - tx_last=1 with the final byte. For len=0 (not produced by LOAD) that byte is the PID.
    - On the accepted last byte -> WAIT.
  - WAIT:
    - hs_ack: flip toggle[ep], clear held[ep] -> IDLE.
    - hs_timeout: keep held[ep] and toggle -> IDLE. The next IN retransmits the identical packet and PID.
    - If hs_ack and hs_timeout occur together, ACK wins.
  - HS:
    - Drive the single handshake byte with tx_last=1 until tx_ready, then -> IDLE.
    - Toggle and held are unchanged.
- token_valid is ignored outside IDLE (no queueing).
- toggle_clr[i] takes effect in any state for i != active ep. For the active ep it is applied on return to IDLE.
- stall overrides held data: the buffer is retained, and is sent once stall clears.
- A FIFO written during LOAD does not extend n. n is frozen at the IN token.
- usedw==0 with empty==0 cannot occur. If it does, the packet is treated as a zero-length DATA packet.
- busy = (state != IDLE).

Test Plan:
- Reset low 2 cycles, EP1 FIFO holds 3 bytes {0x11,0x22,0x33}, IN ep1, tx_ready=1 -> fifo_rdreq[1] high 3 cycles; tx bytes 0xC3,0x11,0x22,0x33 with tx_last on 0x33; hs_ack -> next 3-byte IN to ep1 sends 0x4B first.
- EP0 FIFO holds 12 bytes, IN ep0, ACK, IN ep0 -> first packet 8 bytes DATA0, second packet 4 bytes DATA1, FIFO empty afterwards.
- IN ep1 with 2 bytes, hs_timeout, IN ep1 again -> no rdreq on the second IN; identical 0xC3,b0,b1 resent; ACK then flips toggle.
- IN ep0 with FIFO empty -> single byte 0x5A, tx_last=1, no rdreq, toggle unchanged. Set stall[0] -> 0x1E.
- tx_ready held low 5 cycles mid-packet -> tx_data/tx_valid stable across stall; no byte skipped or duplicated. Assert reset (0) during SEND -> tx_valid=0 next cycle, toggles back to DATA0.
- toggle_clr[1] while ep1 held with DATA1 -> next IN ep1 loads fresh FIFO data with PID 0xC3. Token endp=5 -> ignored, busy stays 0.
